cdb_arbiter: RTL and testbench

//  Shares the single common data bus (CDB) between the two result producers: ALU (port A) and LSB (port B).

---
 rtl/cdb_arbiter.sv | 158 +++++++++++++++
 tb/tb_cdb_arbiter.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: two producer FIFOs (ALU, LSB) drained round-robin,
// one registered broadcast per cycle.
module cdb_arbiter #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned TAG_W      = 4,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              rollback_signal,
  input  logic              alu_valid,
  input  logic [TAG_W-1:0]  alu_tag,
  input  logic [DATA_W-1:0] alu_data,
  output logic              alu_full,
  input  logic              lsb_valid,
  input  logic [TAG_W-1:0]  lsb_tag,
  input  logic [DATA_W-1:0] lsb_data,
  output logic              lsb_full,
  output logic              cdb_valid,
  output logic [TAG_W-1:0]  cdb_tag,
  output logic [DATA_W-1:0] cdb_data,
  output logic              cdb_src,
  output logic              ovf_err
);

  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW = PtrW + 1;
  localparam int unsigned EntW = TAG_W + DATA_W;

  // Index 0 = ALU, index 1 = LSB throughout.
  logic [EntW-1:0] mem_q [2][FIFO_DEPTH];
  logic [PtrW-1:0] wr_ptr_q [2];
  logic [PtrW-1:0] wr_ptr_d [2];
  logic [PtrW-1:0] rd_ptr_q [2];
  logic [PtrW-1:0] rd_ptr_d [2];
  logic [CntW-1:0] count_q  [2];
  logic [CntW-1:0] count_d  [2];

  logic              last_grant_q, last_grant_d;
  logic              cdb_valid_q, cdb_valid_d;
  logic [TAG_W-1:0]  cdb_tag_q, cdb_tag_d;
  logic [DATA_W-1:0] cdb_data_q, cdb_data_d;
  logic              cdb_src_q, cdb_src_d;
  logic              ovf_err_q, ovf_err_d;

  logic [1:0]       in_valid;
  logic [TAG_W-1:0] in_tag [2];
  logic [EntW-1:0]  in_ent [2];
  logic [1:0]       full;
  logic [1:0]       nonempty;
  logic [1:0]       push_ok;
  logic [1:0]       push_bad;
  logic             accept;
  logic             grant;
  logic             pop_any;
  logic [EntW-1:0]  head;

  assign in_valid  = {lsb_valid, alu_valid};
  assign in_tag[0] = alu_tag;
  assign in_tag[1] = lsb_tag;
  assign in_ent[0] = {alu_tag, alu_data};
  assign in_ent[1] = {lsb_tag, lsb_data};

  assign alu_full  = full[0];
  assign lsb_full  = full[1];
  assign cdb_valid = cdb_valid_q;
  assign cdb_tag   = cdb_tag_q;
  assign cdb_data  = cdb_data_q;
  assign cdb_src   = cdb_src_q;
  assign ovf_err   = ovf_err_q;

  // Push qualification, occupancy flags and round-robin grant.
  always_comb begin
    accept = rdy && !rollback_signal;
    for (int i = 0; i < 2; i++) begin
      full[i]     = (count_q[i] == CntW'(FIFO_DEPTH));
      nonempty[i] = (count_q[i] != '0);
      push_ok[i]  = accept && in_valid[i] && !full[i] && (in_tag[i] != '0);
      push_bad[i] = accept && in_valid[i] && (full[i] || (in_tag[i] == '0));
    end
    // Both waiting: the side that did not win last time goes next.
    if (&nonempty) grant = ~last_grant_q;
    else           grant = nonempty[1];
    pop_any = accept && (|nonempty);
    head    = mem_q[grant][rd_ptr_q[grant]];
  end

  // Next-state for pointers, counts and the broadcast register.
  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    last_grant_d = last_grant_q;
    cdb_valid_d  = 1'b0;
    cdb_tag_d    = cdb_tag_q;
    cdb_data_d   = cdb_data_q;
    cdb_src_d    = cdb_src_q;
    ovf_err_d    = ovf_err_q | (|push_bad);
    if (rollback_signal) begin
      for (int i = 0; i < 2; i++) begin
        wr_ptr_d[i] = '0;
        rd_ptr_d[i] = '0;
        count_d[i]  = '0;
      end
      last_grant_d = 1'b1;
    end else if (rdy) begin
      for (int i = 0; i < 2; i++) begin
        if (push_ok[i]) wr_ptr_d[i] = wr_ptr_q[i] + PtrW'(1);
        if (pop_any && (grant == i[0])) rd_ptr_d[i] = rd_ptr_q[i] + PtrW'(1);
        count_d[i] = count_q[i] + CntW'(push_ok[i])
                   - CntW'(pop_any && (grant == i[0]));
      end
      if (pop_any) begin
        cdb_valid_d  = 1'b1;
        cdb_tag_d    = head[EntW-1:DATA_W];
        cdb_data_d   = head[DATA_W-1:0];
        cdb_src_d    = grant;
        last_grant_d = grant;
      end
    end
  end

  // Control state with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 2; i++) begin
        wr_ptr_q[i] <= '0;
        rd_ptr_q[i] <= '0;
        count_q[i]  <= '0;
      end
      last_grant_q <= 1'b1;
      cdb_valid_q  <= 1'b0;
      cdb_tag_q    <= '0;
      cdb_data_q   <= '0;
      cdb_src_q    <= 1'b0;
      ovf_err_q    <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      last_grant_q <= last_grant_d;
      cdb_valid_q  <= cdb_valid_d;
      cdb_tag_q    <= cdb_tag_d;
      cdb_data_q   <= cdb_data_d;
      cdb_src_q    <= cdb_src_d;
      ovf_err_q    <= ovf_err_d;
    end
  end

  // FIFO storage; contents are only meaningful below count, so no reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (push_ok[i]) mem_q[i][wr_ptr_q[i]] <= in_ent[i];
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed self-checking bench for cdb_arbiter.
module tb_cdb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic        rollback_signal;
  logic        alu_valid;
  logic [3:0]  alu_tag;
  logic [31:0] alu_data;
  logic        alu_full;
  logic        lsb_valid;
  logic [3:0]  lsb_tag;
  logic [31:0] lsb_data;
  logic        lsb_full;
  logic        cdb_valid;
  logic [3:0]  cdb_tag;
  logic [31:0] cdb_data;
  logic        cdb_src;
  logic        ovf_err;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  cdb_arbiter #(
    .DATA_W     (32),
    .TAG_W      (4),
    .FIFO_DEPTH (4)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .rdy             (rdy),
    .rollback_signal (rollback_signal),
    .alu_valid       (alu_valid),
    .alu_tag         (alu_tag),
    .alu_data        (alu_data),
    .alu_full        (alu_full),
    .lsb_valid       (lsb_valid),
    .lsb_tag         (lsb_tag),
    .lsb_data        (lsb_data),
    .lsb_full        (lsb_full),
    .cdb_valid       (cdb_valid),
    .cdb_tag         (cdb_tag),
    .cdb_data        (cdb_data),
    .cdb_src         (cdb_src),
    .ovf_err         (ovf_err)
  );

  task automatic check_eq(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // Apply one set of pushes across a rising edge, then sample 1 time unit later.
  task automatic cyc(input logic av, input logic [3:0] at, input logic [31:0] ad,
                     input logic lv, input logic [3:0] lt, input logic [31:0] ld);
    alu_valid = av; alu_tag = at; alu_data = ad;
    lsb_valid = lv; lsb_tag = lt; lsb_data = ld;
    @(posedge clk);
    #1;
    alu_valid = 1'b0;
    lsb_valid = 1'b0;
    rollback_signal = 1'b0;
  endtask

  task automatic idle();
    cyc(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0);
  endtask

  task automatic exp_cdb(input string name, input logic v, input logic [3:0] t,
                         input logic [31:0] d, input logic s);
    check_eq({name, ".valid"}, {63'd0, cdb_valid}, {63'd0, v});
    if (v) begin
      check_eq({name, ".tag"}, {60'd0, cdb_tag}, {60'd0, t});
      check_eq({name, ".data"}, {32'd0, cdb_data}, {32'd0, d});
      check_eq({name, ".src"}, {63'd0, cdb_src}, {63'd0, s});
    end
  endtask

  task automatic do_reset();
    rst = 1'b0; rdy = 1'b1; rollback_signal = 1'b0;
    alu_valid = 1'b0; alu_tag = '0; alu_data = '0;
    lsb_valid = 1'b0; lsb_tag = '0; lsb_data = '0;
    @(negedge clk);
    rst = 1'b1;
    #1;
  endtask

  // Expected broadcast tags after each edge of the fill test (0 = none).
  logic [3:0] t3_tag [12];

  initial begin
    t3_tag = '{4'd0, 4'd1, 4'd9, 4'd2, 4'd10, 4'd3, 4'd11, 4'd4, 4'd5, 4'd6, 4'd7, 4'd0};

    // Reset state
    do_reset();
    check_eq("rst.valid", {63'd0, cdb_valid}, 64'd0);
    check_eq("rst.tag", {60'd0, cdb_tag}, 64'd0);
    check_eq("rst.data", {32'd0, cdb_data}, 64'd0);
    check_eq("rst.src", {63'd0, cdb_src}, 64'd0);
    check_eq("rst.ovf", {63'd0, ovf_err}, 64'd0);
    check_eq("rst.full", {62'd0, lsb_full, alu_full}, 64'd0);

    // 1: single ALU result, one cycle latency, then idle with tag held
    cyc(1'b1, 4'd3, 32'h11, 1'b0, 4'd0, 32'd0);
    exp_cdb("t1.e0", 1'b0, 4'd0, 32'd0, 1'b0);
    idle();
    exp_cdb("t1.e1", 1'b1, 4'd3, 32'h11, 1'b0);
    idle();
    exp_cdb("t1.e2", 1'b0, 4'd0, 32'd0, 1'b0);
    check_eq("t1.hold_tag", {60'd0, cdb_tag}, 64'd3);

    // 2: both producers with two entries, ALU wins first after reset
    do_reset();
    cyc(1'b1, 4'd1, 32'hA1, 1'b1, 4'd5, 32'hB1);
    cyc(1'b1, 4'd2, 32'hA2, 1'b1, 4'd6, 32'hB2);
    exp_cdb("t2.a1", 1'b1, 4'd1, 32'hA1, 1'b0);
    idle(); exp_cdb("t2.l1", 1'b1, 4'd5, 32'hB1, 1'b1);
    idle(); exp_cdb("t2.a2", 1'b1, 4'd2, 32'hA2, 1'b0);
    idle(); exp_cdb("t2.l2", 1'b1, 4'd6, 32'hB2, 1'b1);
    idle(); exp_cdb("t2.end", 1'b0, 4'd0, 32'd0, 1'b0);

    // 3: ALU fills while sharing the bus with LSB; push on full is dropped
    do_reset();
    for (int e = 0; e < 12; e++) begin
      logic       av;
      logic       lv;
      logic [3:0] at;
      logic [3:0] lt;
      av = (e < 8);
      lv = (e < 3);
      at = 4'(e + 1);
      lt = 4'(e + 9);
      cyc(av, at, 32'hA000 + 32'(at), lv, lt, 32'hB000 + 32'(lt));
      if (t3_tag[e] == 4'd0)
        exp_cdb($sformatf("t3.e%0d", e), 1'b0, 4'd0, 32'd0, 1'b0);
      else if (t3_tag[e] >= 4'd9)
        exp_cdb($sformatf("t3.e%0d", e), 1'b1, t3_tag[e], 32'hB000 + 32'(t3_tag[e]), 1'b1);
      else
        exp_cdb($sformatf("t3.e%0d", e), 1'b1, t3_tag[e], 32'hA000 + 32'(t3_tag[e]), 1'b0);
      if (e == 5) check_eq("t3.notfull5", {63'd0, alu_full}, 64'd0);
      if (e == 6) begin
        check_eq("t3.full6", {63'd0, alu_full}, 64'd1);
        check_eq("t3.noovf6", {63'd0, ovf_err}, 64'd0);
      end
      if (e == 7) begin
        check_eq("t3.notfull7", {63'd0, alu_full}, 64'd0);
        check_eq("t3.ovf7", {63'd0, ovf_err}, 64'd1);
      end
    end
    rollback_signal = 1'b1;
    idle();
    check_eq("t3.ovf_sticky_rb", {63'd0, ovf_err}, 64'd1);

    // 4: rollback with three entries queued and an LSB push on the same edge
    do_reset();
    cyc(1'b1, 4'd1, 32'hA1, 1'b1, 4'd5, 32'hB1);
    cyc(1'b1, 4'd2, 32'hA2, 1'b1, 4'd6, 32'hB2);
    exp_cdb("t4.a1", 1'b1, 4'd1, 32'hA1, 1'b0);
    rollback_signal = 1'b1;
    cyc(1'b0, 4'd0, 32'd0, 1'b1, 4'd7, 32'hB3);
    exp_cdb("t4.rb", 1'b0, 4'd0, 32'd0, 1'b0);
    check_eq("t4.full", {62'd0, lsb_full, alu_full}, 64'd0);
    check_eq("t4.ovf", {63'd0, ovf_err}, 64'd0);
    for (int k = 0; k < 4; k++) begin
      idle();
      exp_cdb($sformatf("t4.quiet%0d", k), 1'b0, 4'd0, 32'd0, 1'b0);
    end

    // 5: rdy pause freezes queues and round-robin state
    do_reset();
    cyc(1'b1, 4'd1, 32'hA1, 1'b1, 4'd5, 32'hB1);
    cyc(1'b1, 4'd2, 32'hA2, 1'b1, 4'd6, 32'hB2);
    exp_cdb("t5.a1", 1'b1, 4'd1, 32'hA1, 1'b0);
    rdy = 1'b0;
    for (int k = 0; k < 3; k++) begin
      idle();
      exp_cdb($sformatf("t5.pause%0d", k), 1'b0, 4'd0, 32'd0, 1'b0);
    end
    rdy = 1'b1;
    idle(); exp_cdb("t5.l1", 1'b1, 4'd5, 32'hB1, 1'b1);
    idle(); exp_cdb("t5.a2", 1'b1, 4'd2, 32'hA2, 1'b0);
    idle(); exp_cdb("t5.l2", 1'b1, 4'd6, 32'hB2, 1'b1);
    idle(); exp_cdb("t5.end", 1'b0, 4'd0, 32'd0, 1'b0);

    // 6: tag 0 push is rejected; async reset clears outputs between edges
    do_reset();
    cyc(1'b1, 4'd0, 32'h99, 1'b0, 4'd0, 32'd0);
    check_eq("t6.ovf", {63'd0, ovf_err}, 64'd1);
    cyc(1'b1, 4'd4, 32'h44, 1'b0, 4'd0, 32'd0);
    exp_cdb("t6.nobcast", 1'b0, 4'd0, 32'd0, 1'b0);
    idle();
    exp_cdb("t6.bcast", 1'b1, 4'd4, 32'h44, 1'b0);
    #2;
    rst = 1'b0;
    #1;
    check_eq("t6.arst_valid", {63'd0, cdb_valid}, 64'd0);
    check_eq("t6.arst_ovf", {63'd0, ovf_err}, 64'd0);
    check_eq("t6.arst_tag", {60'd0, cdb_tag}, 64'd0);
    @(negedge clk);
    rst = 1'b1;
    idle();
    exp_cdb("t6.after", 1'b0, 4'd0, 32'd0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
